// File: rtl/waterfall_pixgen.sv
// ============================================================================
// waterfall_pixgen : scrolling spectrum-row buffer with heat-map pixel output.
// Optional grid overlay enabled by defining WATERFALL_GRID_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module waterfall_pixgen #(
  parameter int COLS      = 320,
  parameter int ROWS      = 240,
  parameter int GRID_STEP = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic        visible,
  input  logic        start,
  output logic [23:0] rgb_data,
  output logic [8:0]  rows_filled
);

  localparam int c_COL_W = $clog2(COLS);
  localparam int c_ROW_W = $clog2(ROWS + 1);

  localparam logic [0:0] c_S_FILL = 1'b0;
  localparam logic [0:0] c_S_WAIT = 1'b1;

  if (GRID_STEP < 2 || (GRID_STEP & (GRID_STEP - 1)) != 0) begin : g_grid_step_bad
    $error("GRID_STEP must be a power of two of at least 2");
  end

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_wr_row;
  logic [c_ROW_W-1:0] r_newest;
  logic [8:0]         r_rows_filled;
  logic               w_accept;
  logic               w_last;
  logic               w_wr_en;
  logic               w_commit;

  logic [7:0]         r_mem [0:ROWS][0:COLS-1];

  assign w_accept    = sample_valid && r_ready;
  assign w_last      = (r_col == c_COL_W'(COLS - 1));
  assign w_ready_nxt = (w_state_nxt == c_S_FILL);

  // State register and write-side bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_S_FILL;
      r_ready       <= 1'b0;
      r_col         <= '0;
      r_wr_row      <= '0;
      r_newest      <= '0;
      r_rows_filled <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      if (w_wr_en) begin
        r_col <= w_last ? '0 : r_col + c_COL_W'(1);
      end
      if (w_commit) begin
        r_newest <= r_wr_row;
        r_wr_row <= (r_wr_row == c_ROW_W'(ROWS)) ? '0 : r_wr_row + c_ROW_W'(1);
        if (r_rows_filled < 9'(ROWS)) begin
          r_rows_filled <= r_rows_filled + 9'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_FILL: if (w_accept && w_last) w_state_nxt = c_S_WAIT;
      c_S_WAIT: if (start) w_state_nxt = c_S_FILL;
      default:  w_state_nxt = c_S_FILL;
    endcase
  end

  always_comb begin
    w_wr_en  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      c_S_FILL: w_wr_en  = w_accept;
      c_S_WAIT: w_commit = start;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_row][r_col] <= sample_data;
    end
  end

  // Line y shows the row committed y commits ago, modulo the ROWS+1 ring
  logic [9:0]         w_newest_ext;
  logic [9:0]         w_y_ext;
  logic [c_ROW_W-1:0] w_rd_row;
  logic [c_COL_W-1:0] w_rd_col;

  assign w_newest_ext = 10'(r_newest);
  assign w_y_ext      = 10'(y);
  assign w_rd_row     = c_ROW_W'((w_newest_ext >= w_y_ext) ? (w_newest_ext - w_y_ext)
                                 : (w_newest_ext + 10'(ROWS + 1) - w_y_ext));
  assign w_rd_col     = x[c_COL_W-1:0];

  logic [7:0]  r_rd_data;
  logic        r_vis1;
  logic [7:0]  r_y1;
  logic [23:0] r_rgb;
  logic [23:0] w_rgb_nxt;
  logic [23:0] w_pal;
  logic [7:0]  w_s;
  logic        w_show;

  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[w_rd_row][w_rd_col];
  end

  assign w_s    = {r_rd_data[5:0], 2'b00};
  assign w_show = r_vis1 && (9'(r_y1) < r_rows_filled);

  always_comb begin
    w_pal = 24'h0;
    case (r_rd_data[7:6])
      2'd0:    w_pal = {8'h00, 8'h00, w_s};
      2'd1:    w_pal = {w_s, 8'h00, 8'hFC};
      2'd2:    w_pal = {8'hFC, w_s, 8'hFC - w_s};
      default: w_pal = {8'hFC, 8'hFC, w_s};
    endcase
  end

`ifdef WATERFALL_GRID_EN
  localparam int c_GRID_W = $clog2(GRID_STEP);
  logic [c_GRID_W-1:0] r_xg1;
  logic                w_grid;

  always_ff @(posedge clk) begin
    r_xg1 <= x[c_GRID_W-1:0];
  end

  assign w_grid    = (r_xg1 == '0) || (r_y1[c_GRID_W-1:0] == '0);
  assign w_rgb_nxt = !w_show ? 24'h0 : (w_grid ? 24'h404040 : w_pal);
`else
  assign w_rgb_nxt = w_show ? w_pal : 24'h0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vis1 <= 1'b0;
      r_y1   <= '0;
      r_rgb  <= '0;
    end else begin
      r_vis1 <= visible;
      r_y1   <= y;
      r_rgb  <= w_rgb_nxt;
    end
  end

  assign sample_ready = r_ready;
  assign rgb_data     = r_rgb;
  assign rows_filled  = r_rows_filled;

endmodule

`default_nettype wire

// File: tb/tb_waterfall_pixgen.sv
// ============================================================================
// tb_waterfall_pixgen : scoreboard bench for waterfall_pixgen (COLS=32, ROWS=24).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_waterfall_pixgen;

  localparam int COLS = 32;
  localparam int ROWS = 24;
  localparam int NROW = ROWS + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sample_data = 8'h00;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [8:0]  x = 9'd0;
  logic [7:0]  y = 8'd0;
  logic        visible = 1'b0;
  logic        start = 1'b0;
  logic [23:0] rgb_data;
  logic [8:0]  rows_filled;

  waterfall_pixgen #(.COLS(COLS), .ROWS(ROWS), .GRID_STEP(32)) dut (
    .clk(clk), .reset(reset),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .x(x), .y(y), .visible(visible), .start(start),
    .rgb_data(rgb_data), .rows_filled(rows_filled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the stored rows and commit state
  logic [7:0] tb_mem [NROW][COLS];
  int m_newest = 0, m_wr_row = 0, m_rows_filled = 0;
  bit m_full = 0;
  int vectors = 0, miscompares = 0;

  typedef struct { int due; logic [23:0] exp; int px; int py; } exp_t;
  exp_t exp_q[$];

  function automatic logic [23:0] pal(input logic [7:0] m);
    logic [7:0] s;
    s = {m[5:0], 2'b00};
    case (m[7:6])
      2'd0:    return {16'h0000, s};
      2'd1:    return {s, 8'h00, 8'hFC};
      2'd2:    return {8'hFC, s, 8'hFC - s};
      default: return {8'hFC, 8'hFC, s};
    endcase
  endfunction

  function automatic logic [23:0] model_px(input int px, input int py, input bit vis);
    if (!vis || py >= m_rows_filled) return 24'h0;
`ifdef WATERFALL_GRID_EN
    if (px % 32 == 0 || py % 32 == 0) return 24'h404040;
`endif
    return pal(tb_mem[(m_newest - py + NROW) % NROW][px]);
  endfunction

  task automatic scan(input int ylo, input int yhi, input bit vis);
    int n, i, guard;
    exp_t e;
    n = (yhi - ylo + 1) * COLS;
    i = 0;
    guard = 0;
    while ((i < n || exp_q.size() != 0) && guard < n + 20) begin
      @(posedge clk); #1;
      if (i < n) begin
        x = 9'(i % COLS);
        y = 8'(ylo + i / COLS);
        visible = vis;
        e.due = cyc + 2;
        e.px = i % COLS;
        e.py = ylo + i / COLS;
        e.exp = model_px(e.px, e.py, vis);
        exp_q.push_back(e);
        i++;
      end else begin
        visible = 1'b0;
      end
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        vectors++;
        if (rgb_data !== e.exp) begin
          miscompares++;
          $display("FAIL pixel(%0d,%0d): got %h expected %h", e.px, e.py, rgb_data, e.exp);
        end
      end
      guard++;
    end
    visible = 1'b0;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scan_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic stream(input logic [7:0] vals [COLS], input int ncols);
    int col, guard;
    col = 0;
    guard = 0;
    while (col < ncols && guard < 200) begin
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_data = vals[col];
      @(negedge clk);
      if (sample_ready) begin
        tb_mem[m_wr_row][col] = vals[col];
        col++;
      end
      guard++;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    if (col == COLS) m_full = 1;
    if (col < ncols) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_timeout: got %0d accepted expected %0d", col, ncols);
    end
  endtask

  task automatic model_commit();
    if (m_full) begin
      m_newest = m_wr_row;
      m_wr_row = (m_wr_row + 1) % NROW;
      if (m_rows_filled < ROWS) m_rows_filled++;
      m_full = 0;
    end
  endtask

  task automatic commit();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_commit();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    sample_valid = 1'b0;
    start = 1'b0;
    visible = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_newest = 0;
    m_wr_row = 0;
    m_rows_filled = 0;
    m_full = 0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (rgb_data !== 24'h0 || rows_filled !== 9'd0 || sample_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: got rgb=%h rows=%0d rdy=%b expected 0/0/0",
                 rgb_data, rows_filled, sample_ready);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (sample_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_at_release: got %b expected 0", sample_ready);
    end
    @(negedge clk);
    vectors++;
    if (sample_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release: got %b expected 1", sample_ready);
    end
    scan(0, 0, 1);
  endtask

  task automatic test_single_row();
    logic [7:0] v [COLS];
    foreach (v[c]) v[c] = 8'h20;
    stream(v, COLS);
    commit();
    @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd1) begin
      miscompares++;
      $display("FAIL single_rows_filled: got %0d expected 1", rows_filled);
    end
    scan(0, 1, 1);
  endtask

  task automatic test_palette();
    logic [7:0] v [COLS];
    foreach (v[c]) v[c] = 8'(c * 8);
    v[3] = 8'hC1;
    v[4] = 8'h7F;
    v[5] = 8'h80;
    stream(v, COLS);
    commit();
    @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd2) begin
      miscompares++;
      $display("FAIL palette_rows_filled: got %0d expected 2", rows_filled);
    end
    scan(0, 2, 1);
  endtask

  task automatic test_scroll();
    logic [7:0] v [COLS];
    do_reset();
    for (int k = 0; k < 26; k++) begin
      foreach (v[c]) v[c] = 8'(k);
      stream(v, COLS);
      commit();
    end
    @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd24) begin
      miscompares++;
      $display("FAIL scroll_rows_filled: got %0d expected 24", rows_filled);
    end
    scan(0, 23, 1);
    scan(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [COLS];
    logic [7:0] w [COLS];
    do_reset();
    foreach (v[c]) v[c] = 8'(8'h40 + c);
    foreach (w[c]) w[c] = 8'(8'hA0 + c * 2);
    stream(v, COLS);
    repeat (4) begin
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_data = 8'hFF;
      @(negedge clk);
      vectors++;
      if (sample_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_ready: got %b expected 0", sample_ready);
      end
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    vectors++;
    if (sample_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_ready: got %b expected 0", sample_ready);
    end
    @(posedge clk); #1;
    start = 1'b0;
    sample_valid = 1'b0;
    model_commit();
    @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd1) begin
      miscompares++;
      $display("FAIL held_rows_filled: got %0d expected 1", rows_filled);
    end
    scan(0, 0, 1);
    // Last sample and start arrive together: no commit yet
    stream(w, COLS - 1);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_data = w[COLS-1];
    start = 1'b1;
    @(negedge clk);
    vectors++;
    if (sample_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL last_ready: got %b expected 1", sample_ready);
    end
    tb_mem[m_wr_row][COLS-1] = w[COLS-1];
    m_full = 1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd1) begin
      miscompares++;
      $display("FAIL coincident_rows_filled: got %0d expected 1", rows_filled);
    end
    scan(0, 1, 1);
    commit();
    @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd2) begin
      miscompares++;
      $display("FAIL late_commit_rows_filled: got %0d expected 2", rows_filled);
    end
    scan(0, 2, 1);
  endtask

  task automatic test_reset_midrow();
    logic [7:0] v [COLS];
    logic [7:0] w [COLS];
    foreach (v[c]) v[c] = 8'(8'hE0 + c / 4);
    foreach (w[c]) w[c] = 8'(c * 7);
    stream(v, 10);
    do_reset();
    @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd0 || rgb_data !== 24'h0) begin
      miscompares++;
      $display("FAIL midrow_reset: got rows=%0d rgb=%h expected 0/000000", rows_filled, rgb_data);
    end
    scan(0, 0, 1);
    stream(w, COLS);
    commit();
    @(negedge clk);
    vectors++;
    if (rows_filled !== 9'd1) begin
      miscompares++;
      $display("FAIL midrow_rows_filled: got %0d expected 1", rows_filled);
    end
    scan(0, 1, 1);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_palette();
    test_scroll();
    test_back_to_back();
    test_reset_midrow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
